// File: rtl/pstprc_upload_framer.sv
// pstprc_upload_framer
// Buffers 64-bit I/Q demodulation results and emits one framed 32-bit word
// stream per trigger: header, then I and Q of each result, over valid/ready.
// Optional feature macro: UPLOAD_CHKSUM_EN appends an XOR checksum word
// (CHK state) after the last Q word of every frame.
module pstprc_upload_framer #(
  parameter int          DEPTH = 16,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pstprc_fifo_wren,
  input  logic [63:0] pstprc_IQ_seq_o,
  input  logic        Pstprc_finish,
  input  logic        pstprc_num_en,
  input  logic [3:0]  Pstprc_num,
  output logic [31:0] upl_data,
  output logic        upl_valid,
  input  logic        upl_ready,
  output logic        upl_last,
  output logic [15:0] frm_cnt,
  output logic        ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef UPLOAD_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DQ_I, DQ_Q, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, DQ_I, DQ_Q} state_t;
`endif

  state_t state_reg, state_next;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0] count;
  logic [3:0]    num_reg, n_frm, pend, res_cnt, res_next;
  logic          full, wr_ok, pop, accept, start_ok, frame_start, frame_end;
  logic [63:0]   head;
  logic [31:0]   next_i;
  logic [31:0]   data_next;
  logic          valid_next, last_next;
`ifdef UPLOAD_CHKSUM_EN
  logic [31:0]   chk_reg, chk_next;
`endif

  assign full       = (count == CW'(DEPTH));
  assign wr_ok      = pstprc_fifo_wren && !full;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign head       = mem[rd_ptr];
  // I word of the entry behind the head, needed when popping and continuing
  assign next_i     = mem[rd_ptr_inc][63:32];
  assign accept     = upl_valid && upl_ready;
  assign start_ok   = (pend != 4'd0) && (count >= {{(CW-4){1'b0}}, num_reg});

  // Result storage; no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= pstprc_IQ_seq_o;
  end

  // Next-state and next-output logic; outputs hold unless a transition occurs
  always_comb begin
    state_next  = state_reg;
    data_next   = upl_data;
    valid_next  = upl_valid;
    last_next   = upl_last;
    pop         = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    res_next    = res_cnt;
`ifdef UPLOAD_CHKSUM_EN
    chk_next    = chk_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next  = HDR;
          frame_start = 1'b1;
          valid_next  = 1'b1;
          data_next   = {SYNC, 4'h0, num_reg, frm_cnt};
          res_next    = 4'd0;
`ifdef UPLOAD_CHKSUM_EN
          last_next   = 1'b0;
          chk_next    = 32'h0;
`else
          last_next   = (num_reg == 4'd0);
`endif
        end
      end
      HDR: begin
        if (accept) begin
          if (n_frm != 4'd0) begin
            state_next = DQ_I;
            data_next  = head[63:32];
            last_next  = 1'b0;
          end else begin
`ifdef UPLOAD_CHKSUM_EN
            state_next = CHK;
            data_next  = 32'h0;
            last_next  = 1'b1;
`else
            state_next = IDLE;
            frame_end  = 1'b1;
            valid_next = 1'b0;
            data_next  = 32'h0;
            last_next  = 1'b0;
`endif
          end
        end
      end
      DQ_I: begin
        if (accept) begin
          state_next = DQ_Q;
          data_next  = head[31:0];
`ifdef UPLOAD_CHKSUM_EN
          chk_next   = chk_reg ^ upl_data;
          last_next  = 1'b0;
`else
          last_next  = (res_cnt == n_frm - 4'd1);
`endif
        end
      end
      DQ_Q: begin
        if (accept) begin
          pop      = 1'b1;
          res_next = res_cnt + 4'd1;
`ifdef UPLOAD_CHKSUM_EN
          chk_next = chk_reg ^ upl_data;
`endif
          if (res_cnt == n_frm - 4'd1) begin
`ifdef UPLOAD_CHKSUM_EN
            state_next = CHK;
            data_next  = chk_reg ^ upl_data;
            last_next  = 1'b1;
`else
            state_next = IDLE;
            frame_end  = 1'b1;
            valid_next = 1'b0;
            data_next  = 32'h0;
            last_next  = 1'b0;
`endif
          end else begin
            state_next = DQ_I;
            data_next  = next_i;
            last_next  = 1'b0;
          end
        end
      end
`ifdef UPLOAD_CHKSUM_EN
      CHK: begin
        if (accept) begin
          state_next = IDLE;
          frame_end  = 1'b1;
          valid_next = 1'b0;
          data_next  = 32'h0;
          last_next  = 1'b0;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State, FIFO bookkeeping, counters and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      num_reg   <= 4'd1;
      n_frm     <= 4'd0;
      pend      <= 4'd0;
      res_cnt   <= 4'd0;
      frm_cnt   <= 16'd0;
      ovf_err   <= 1'b0;
      upl_data  <= 32'h0;
      upl_valid <= 1'b0;
      upl_last  <= 1'b0;
`ifdef UPLOAD_CHKSUM_EN
      chk_reg   <= 32'h0;
`endif
    end else begin
      state_reg <= state_next;
      upl_data  <= data_next;
      upl_valid <= valid_next;
      upl_last  <= last_next;
      res_cnt   <= res_next;
`ifdef UPLOAD_CHKSUM_EN
      chk_reg   <= chk_next;
`endif
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr_inc;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A full FIFO drops the write even if a pop happens the same cycle
      if (pstprc_fifo_wren && full) ovf_err <= 1'b1;
      if (pstprc_num_en) num_reg <= Pstprc_num;
      if (frame_start) n_frm <= num_reg;
      // A finish pulse and a frame start in the same cycle cancel out
      case ({Pstprc_finish, frame_start})
        2'b10:   if (pend != 4'd15) pend <= pend + 4'd1;
        2'b01:   pend <= pend - 4'd1;
        default: pend <= pend;
      endcase
      if (frame_end) frm_cnt <= frm_cnt + 16'd1;
    end
  end

endmodule
